cdma_chip_despreader: RTL and testbench

//  Serial-chip CDMA receive front end: consumes one spread chip per valid cycle, correlates it against
//  the four 4-chip Walsh codes and rebuilds each user's 4-bit data word. It is the far end of a

---
 rtl/cdma_chip_despreader.sv | 191 +++++++++++++++++++
 tb/tb_cdma_chip_despreader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_chip_despreader.sv
// cdma_chip_despreader: chip-serial Walsh despreader for four users.
// Each valid chip is correlated against the four 4-chip codes; after
// 4*WORD_W chips the assembled per-user words are presented together with
// per-user tie flags. Framing violations are reported with a sync_err pulse.
//
// Input handshake: chip_in and chip_sync are consumed only on cycles with
// chip_valid=1; there is no backpressure, so every valid cycle is taken.
// word_valid and sync_err are single-cycle pulses registered on the edge
// that accepts the chip causing them.
module cdma_chip_despreader #(
  parameter int CHIP_W = 8,
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_valid,
  input  logic [CHIP_W-1:0] chip_in,
  input  logic              chip_sync,
  output logic [WORD_W-1:0] user1_out,
  output logic [WORD_W-1:0] user2_out,
  output logic [WORD_W-1:0] user3_out,
  output logic [WORD_W-1:0] user4_out,
  output logic              word_valid,
  output logic [3:0]        tie_flags,
  output logic              sync_err
);

  localparam int ACC_W = CHIP_W + 2;
  localparam int SYM_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(WORD_W - 1);

  // Subtract mask, bit {user, chip}: user1 ++++, user2 +-+-, user3 ++--, user4 +--+
  localparam logic [15:0] CODE_NEG = 16'b0110_1100_1010_0000;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [1:0]                chip_cnt;
  logic [SYM_W-1:0]          sym_cnt;
  logic signed [ACC_W-1:0]   acc     [4];
  logic [WORD_W-1:0]         sr      [4];
  logic [WORD_W-1:0]         user_q  [4];
  logic [3:0]                tie_run;

  logic signed [ACC_W-1:0]   chip_ext;
  logic signed [ACC_W-1:0]   term    [4];
  logic signed [ACC_W-1:0]   sum     [4];
  logic [WORD_W-1:0]         sr_next [4];
  logic [3:0]                sym_bit;
  logic [3:0]                sym_tie;

  logic at_word_start;
  logic sym_last;
  logic word_last;
  logic start_word;
  logic accumulate;
  logic clear_all;
  logic flag_err;

  assign chip_ext      = {{2{chip_in[CHIP_W-1]}}, chip_in};
  assign at_word_start = (chip_cnt == 2'd0) && (sym_cnt == '0);
  assign sym_last      = (chip_cnt == 2'd3);
  assign word_last     = sym_last && (sym_cnt == SYM_LAST);

  // Per-user correlation term, running sum and symbol decision for this chip
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      term[u]    = CODE_NEG[{2'(u), chip_cnt}] ? -chip_ext : chip_ext;
      sum[u]     = (chip_cnt == 2'd0) ? term[u] : acc[u] + term[u];
      sym_tie[u] = (sum[u] == '0);
      // Strictly positive wins a 1; zero resolves to 0 and is flagged as a tie
      sym_bit[u] = !sum[u][ACC_W-1] && !sym_tie[u];
      sr_next[u] = WORD_W'({sr[u], sym_bit[u]});
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and datapath control, including the framing rules
  always_comb begin
    state_next = state;
    start_word = 1'b0;
    accumulate = 1'b0;
    clear_all  = 1'b0;
    flag_err   = 1'b0;
    case (state)
      IDLE: begin
        if (chip_valid && chip_sync) begin
          start_word = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (chip_valid) begin
          if (at_word_start) begin
            if (chip_sync) begin
              start_word = 1'b1;
            end else begin
              // Missing sync at a word boundary: drop the chip and resynchronise
              flag_err   = 1'b1;
              clear_all  = 1'b1;
              state_next = IDLE;
            end
          end else if (chip_sync) begin
            // Early sync: abandon the partial word and restart on this chip
            flag_err   = 1'b1;
            start_word = 1'b1;
          end else begin
            accumulate = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counters, accumulators, shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chip_cnt   <= 2'd0;
      sym_cnt    <= '0;
      tie_run    <= 4'd0;
      tie_flags  <= 4'd0;
      word_valid <= 1'b0;
      sync_err   <= 1'b0;
      for (int u = 0; u < 4; u++) begin
        acc[u]    <= '0;
        sr[u]     <= '0;
        user_q[u] <= '0;
      end
    end else begin
      word_valid <= 1'b0;
      sync_err   <= flag_err;
      if (clear_all) begin
        chip_cnt <= 2'd0;
        sym_cnt  <= '0;
        tie_run  <= 4'd0;
        for (int u = 0; u < 4; u++) begin
          acc[u] <= '0;
          sr[u]  <= '0;
        end
      end else if (start_word) begin
        // Chip 0 of every code is '+', so the accumulator loads the sample itself
        chip_cnt <= 2'd1;
        sym_cnt  <= '0;
        tie_run  <= 4'd0;
        for (int u = 0; u < 4; u++) begin
          acc[u] <= chip_ext;
          sr[u]  <= '0;
        end
      end else if (accumulate) begin
        chip_cnt <= chip_cnt + 2'd1;
        for (int u = 0; u < 4; u++) begin
          acc[u] <= sum[u];
        end
        if (sym_last) begin
          tie_run <= tie_run | sym_tie;
          for (int u = 0; u < 4; u++) begin
            sr[u] <= sr_next[u];
          end
          if (word_last) begin
            sym_cnt    <= '0;
            tie_flags  <= tie_run | sym_tie;
            word_valid <= 1'b1;
            for (int u = 0; u < 4; u++) begin
              user_q[u] <= sr_next[u];
            end
          end else begin
            sym_cnt <= sym_cnt + SYM_W'(1);
          end
        end
      end
    end
  end

  assign user1_out = user_q[0];
  assign user2_out = user_q[1];
  assign user3_out = user_q[2];
  assign user4_out = user_q[3];

endmodule

// File: tb/tb_cdma_chip_despreader.sv
// tb_cdma_chip_despreader: spreads user words with the Walsh codes, feeds
// the chips to the despreader and compares every cycle against a model that
// buffers a whole word of chips and correlates it in one go.
module tb_cdma_chip_despreader;

  logic       clk;
  logic       rst;
  logic       chip_valid;
  logic [7:0] chip_in;
  logic       chip_sync;
  logic [3:0] user1_out, user2_out, user3_out, user4_out;
  logic       word_valid;
  logic [3:0] tie_flags;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int err_cnt = 0;

  // Walsh codes, chip 0 first, users 1..4
  int codes [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};

  // Model state
  int          m_pos = -1;
  int          m_chips [16];
  logic        exp_wv = 1'b0;
  logic        exp_err = 1'b0;
  logic [19:0] exp_q [$];
  logic [19:0] held = 20'd0;

  cdma_chip_despreader #(.CHIP_W(8), .WORD_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .chip_valid (chip_valid),
    .chip_in    (chip_in),
    .chip_sync  (chip_sync),
    .user1_out  (user1_out),
    .user2_out  (user2_out),
    .user3_out  (user3_out),
    .user4_out  (user4_out),
    .word_valid (word_valid),
    .tie_flags  (tie_flags),
    .sync_err   (sync_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chip value for symbol s, chip c of the combined transmit signal
  function automatic int spread(input logic [15:0] w, input int s, input int c);
    int total = 0;
    for (int u = 0; u < 4; u++) begin
      int amp = w[15 - 4*u - s] ? 1 : -1;
      total += amp * codes[u][c];
    end
    return total;
  endfunction

  // Correlate a whole buffered word and queue the expected outputs
  task automatic model_decode();
    logic [3:0] wd [4];
    logic [3:0] tie = 4'd0;
    for (int u = 0; u < 4; u++) begin
      wd[u] = 4'd0;
      for (int s = 0; s < 4; s++) begin
        int corr = 0;
        for (int c = 0; c < 4; c++) corr += codes[u][c] * m_chips[4*s + c];
        wd[u][3 - s] = (corr > 0);
        if (corr == 0) tie[u] = 1'b1;
      end
    end
    exp_q.push_back({wd[0], wd[1], wd[2], wd[3], tie});
  endtask

  // Reference model: framing and word assembly at chip granularity
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos   = -1;
      exp_wv  = 1'b0;
      exp_err = 1'b0;
      exp_q.delete();
    end else begin
      exp_wv  = 1'b0;
      exp_err = 1'b0;
      if (chip_valid) begin
        int v;
        v = $signed(chip_in);
        if (m_pos < 0) begin
          if (chip_sync) begin m_chips[0] = v; m_pos = 1; end
        end else if (m_pos == 0) begin
          if (chip_sync) begin m_chips[0] = v; m_pos = 1; end
          else begin exp_err = 1'b1; m_pos = -1; end
        end else if (chip_sync) begin
          exp_err = 1'b1; m_chips[0] = v; m_pos = 1;
        end else begin
          m_chips[m_pos] = v;
          m_pos++;
          if (m_pos == 16) begin
            model_decode();
            exp_wv = 1'b1;
            m_pos  = 0;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      held = 20'd0;
    end else if (exp_wv) begin
      if (exp_q.size() > 0) held = exp_q.pop_front();
    end
    check("word_valid", 32'(word_valid), 32'(exp_wv));
    check("sync_err", 32'(sync_err), 32'(exp_err));
    check("user_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'(held[19:4]));
    check("tie_flags", 32'(tie_flags), 32'(held[3:0]));
    if (word_valid) wv_cnt++;
    if (sync_err) err_cnt++;
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [7:0] c, input logic s);
    chip_valid = v;
    chip_in    = c;
    chip_sync  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic send_chip(input int c, input logic s, input int max_gap);
    int g;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    idle(g);
    drive(1'b1, 8'(c), s);
  endtask

  // Send the first nchips chips of a spread word; zero_sym forces a symbol to 0
  task automatic send_word(input logic [15:0] w, input int max_gap, input logic [15:0] sync_mask,
                           input int zero_sym, input int nchips);
    for (int k = 0; k < nchips; k++) begin
      int c;
      c = (k / 4 == zero_sym) ? 0 : spread(w, k / 4, k % 4);
      send_chip(c, sync_mask[k], max_gap);
    end
  endtask

  initial begin
    int          wv0, er0, r, nc, zs;
    logic [15:0] w, m;

    rst = 1'b1; chip_valid = 1'b0; chip_in = 8'd0; chip_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check("reset_outputs", 32'({user1_out, user2_out, user3_out, user4_out, tie_flags, word_valid, sync_err}), 32'd0);
    check("model_chip0_sym0", 32'(spread(16'hA6F0, 0, 0)), 32'(0));
    check("model_chip1_sym0", 32'(spread(16'hA6F0, 0, 1)), 32'(4));

    // Clean word
    wv0 = wv_cnt; er0 = err_cnt;
    send_word(16'hA6F0, 0, 16'h0001, -1, 16);
    check("clean_wv_latency", 32'(word_valid), 32'd1);
    check("clean_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h0000A6F0);
    check("clean_ties", 32'(tie_flags), 32'd0);
    idle(3);
    check("clean_wv_count", 32'(wv_cnt - wv0), 32'd1);
    check("clean_err_count", 32'(err_cnt - er0), 32'd0);

    // Same word with gaps
    wv0 = wv_cnt;
    send_word(16'hA6F0, 5, 16'h0001, -1, 16);
    check("gap_wv_latency", 32'(word_valid), 32'd1);
    check("gap_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h0000A6F0);
    idle(2);
    check("gap_wv_count", 32'(wv_cnt - wv0), 32'd1);

    // Back-to-back words
    wv0 = wv_cnt;
    send_word(16'hA6F0, 0, 16'h0001, -1, 16);
    send_word(16'h590F, 0, 16'h0001, -1, 16);
    check("b2b_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h0000590F);
    idle(2);
    check("b2b_wv_count", 32'(wv_cnt - wv0), 32'd2);

    // Tie on symbol 2
    send_word(16'hA6F0, 0, 16'h0001, 2, 16);
    check("tie_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h000084D0);
    check("tie_flags_all", 32'(tie_flags), 32'hF);
    idle(2);

    // Framing: early sync on chip 7, then missing sync at word start
    wv0 = wv_cnt; er0 = err_cnt;
    send_word(16'hA6F0, 0, 16'h0001, -1, 7);
    send_word(16'h590F, 0, 16'h0001, -1, 16);
    check("early_sync_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h0000590F);
    send_word(16'h1234, 0, 16'h0000, -1, 16);
    idle(2);
    check("framing_err_count", 32'(err_cnt - er0), 32'd2);
    check("framing_wv_count", 32'(wv_cnt - wv0), 32'd1);
    send_word(16'h3C5A, 1, 16'h0001, -1, 16);
    check("resync_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h00003C5A);
    idle(2);

    // Reset mid-word
    wv0 = wv_cnt;
    send_word(16'hA6F0, 0, 16'h0001, -1, 9);
    rst = 1'b1;
    #1;
    check("midword_reset", 32'({user1_out, user2_out, user3_out, user4_out, tie_flags, word_valid, sync_err}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check("reset_no_wv", 32'(wv_cnt - wv0), 32'd0);
    send_word(16'h590F, 0, 16'h0001, -1, 16);
    check("post_reset_words", 32'({user1_out, user2_out, user3_out, user4_out}), 32'h0000590F);
    idle(2);

    // Random words with occasional framing faults, partial words and ties
    for (int n = 0; n < 40; n++) begin
      w  = 16'($urandom);
      r  = $urandom_range(9, 0);
      m  = 16'h0001;
      nc = 16;
      zs = -1;
      if (r == 0) m = 16'h0000;
      else if (r == 1) m[$urandom_range(15, 1)] = 1'b1;
      else if (r == 2) nc = $urandom_range(15, 1);
      if ($urandom_range(7, 0) == 0) zs = $urandom_range(3, 0);
      send_word(w, $urandom_range(3, 0), m, zs, nc);
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
